// File: rtl/intersection_pkg.sv
// Shared encodings, lamp constants and phase-sequencing helpers for the intersection controller.
package intersection_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

    typedef enum logic [STATE_W-1:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } state_t;

    typedef struct packed {
        logic [LAMP_W-1:0] ns;
        logic [LAMP_W-1:0] ew;
    } lamps_t;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_GREEN:  next_phase = NS_YELLOW;
            NS_YELLOW: next_phase = ALL_RED_A;
            ALL_RED_A: next_phase = EW_GREEN;
            EW_GREEN:  next_phase = EW_YELLOW;
            EW_YELLOW: next_phase = ALL_RED_B;
            default:   next_phase = NS_GREEN;
        endcase
    endfunction

    // Moore lamp decode; anything unrecognised shows red both ways.
    function automatic lamps_t decode_lamps(input state_t s);
        case (s)
            NS_GREEN:  decode_lamps = '{ns: LAMP_GRN, ew: LAMP_RED};
            NS_YELLOW: decode_lamps = '{ns: LAMP_YEL, ew: LAMP_RED};
            EW_GREEN:  decode_lamps = '{ns: LAMP_RED, ew: LAMP_GRN};
            EW_YELLOW: decode_lamps = '{ns: LAMP_RED, ew: LAMP_YEL};
            default:   decode_lamps = '{ns: LAMP_RED, ew: LAMP_RED};
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 4-bit loadable phase down-counter; priority load > truncate > decrement, never wraps below 0.
module phase_timer
    import intersection_pkg::*;
#(
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned CUT       = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             trunc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= CNT_W'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (trunc) begin
            count <= CNT_W'(CUT);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection phase controller: tick-paced lamp sequencing with pedestrian-shortened greens.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned GREEN_T  = 9,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned PED_CUT  = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              tick,
    input  logic              ped_req,
    output logic [LAMP_W-1:0] ns_light,
    output logic [LAMP_W-1:0] ew_light,
    output logic [CNT_W-1:0]  countdown,
    output logic              ped_wait
);

    state_t           state;
    state_t           state_nxt_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic             trunc_c;
    logic             enter_red_c;
    lamps_t           lamps_nxt_c;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = CNT_W'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: phase_len = CNT_W'(YELLOW_T - 1);
            default:              phase_len = CNT_W'(ALLRED_T - 1);
        endcase
    endfunction

    // Next-state and timer control; an illegal encoding parks in ALL_RED_B with an expired count.
    always_comb begin
        state_nxt_c = state;
        load_c      = 1'b0;
        load_val_c  = '0;
        trunc_c     = 1'b0;
        case (state)
            NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B: begin
                if (tick && (countdown == '0)) begin
                    state_nxt_c = next_phase(state);
                    load_c      = 1'b1;
                    load_val_c  = phase_len(state_nxt_c);
                end
            end
            default: begin
                state_nxt_c = ALL_RED_B;
                load_c      = 1'b1;
                load_val_c  = '0;
            end
        endcase
        trunc_c     = ((state == NS_GREEN) || (state == EW_GREEN)) && ped_wait &&
                      (countdown > CNT_W'(PED_CUT));
        enter_red_c = load_c && ((state_nxt_c == ALL_RED_A) || (state_nxt_c == ALL_RED_B));
        lamps_nxt_c = decode_lamps(state_nxt_c);
    end

    // State, lamps and pedestrian latch; a new request beats the all-red clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= ALL_RED_B;
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
            ped_wait <= 1'b0;
        end else begin
            state    <= state_nxt_c;
            ns_light <= lamps_nxt_c.ns;
            ew_light <= lamps_nxt_c.ew;
            ped_wait <= ped_req || (ped_wait && !enter_red_c);
        end
    end

    phase_timer #(
        .RESET_VAL (ALLRED_T - 1),
        .CUT       (PED_CUT)
    ) u_timer (
        .clock    (CLOCK_50),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .trunc    (trunc_c),
        .dec      (tick),
        .count    (countdown)
    );

endmodule
